// File: rtl/joypad_port_if.sv
// Joypad port bus: APU strobe/read enables and button inputs toward the
// responder, serial data bit and read counters back.
interface joypad_port_if;
   logic       OUT0;
   logic       n_IN0;
   logic       n_IN1;
   logic [7:0] BTN0;
   logic [7:0] BTN1;
   logic       D0_OUT;
   logic       D0_OE;
   logic [3:0] CNT0;
   logic [3:0] CNT1;

   modport master (
      output OUT0, n_IN0, n_IN1, BTN0, BTN1,
      input  D0_OUT, D0_OE, CNT0, CNT1
   );

   modport slave (
      input  OUT0, n_IN0, n_IN1, BTN0, BTN1,
      output D0_OUT, D0_OE, CNT0, CNT1
   );
endinterface

// File: rtl/joypad_port.sv
// Device end of the APU joypad interface: two 8-bit controller shift
// registers loaded by the strobe and shifted out one bit per read on D0.
module joypad_port #(
   parameter int   SYNC_STAGES = 2,
   parameter logic FILL        = 1'b1
) (
   input  logic          CLK,
   input  logic          RES,
   joypad_port_if.slave  bus
);

   logic [SYNC_STAGES-1:0] strobe_sync_q;
   logic [SYNC_STAGES-1:0] rd0_sync_q;
   logic [SYNC_STAGES-1:0] rd1_sync_q;
   logic                   rd0_prev_q;
   logic                   rd1_prev_q;

   logic [7:0] sr0_q,  sr0_d;
   logic [7:0] sr1_q,  sr1_d;
   logic [3:0] cnt0_q, cnt0_d;
   logic [3:0] cnt1_q, cnt1_d;
   logic       d0_out_q, d0_out_d;
   logic       d0_oe_q,  d0_oe_d;

   logic strobe_s;
   logic rd0_s;
   logic rd1_s;
   logic rise0;
   logic rise1;

   assign strobe_s = strobe_sync_q[SYNC_STAGES-1];
   assign rd0_s    = rd0_sync_q[SYNC_STAGES-1];
   assign rd1_s    = rd1_sync_q[SYNC_STAGES-1];
   assign rise0    = ~rd0_prev_q & rd0_s;
   assign rise1    = ~rd1_prev_q & rd1_s;

   always_comb begin
      sr0_d  = sr0_q;
      sr1_d  = sr1_q;
      cnt0_d = cnt0_q;
      cnt1_d = cnt1_q;
      // Load wins over any read edge; registers track BTN while strobe is held.
      if (strobe_s) begin
         sr0_d  = bus.BTN0;
         sr1_d  = bus.BTN1;
         cnt0_d = 4'd0;
         cnt1_d = 4'd0;
      end else begin
         if (rise0) begin
            sr0_d  = {FILL, sr0_q[7:1]};
            cnt0_d = (cnt0_q == 4'd8) ? 4'd8 : cnt0_q + 4'd1;
         end
         if (rise1) begin
            sr1_d  = {FILL, sr1_q[7:1]};
            cnt1_d = (cnt1_q == 4'd8) ? 4'd8 : cnt1_q + 4'd1;
         end
      end
   end

   always_comb begin
      d0_oe_d  = ~rd0_s | ~rd1_s;
      d0_out_d = 1'b0;
      if (!rd0_s) begin
         d0_out_d = sr0_q[0];
      end else if (!rd1_s) begin
         d0_out_d = sr1_q[0];
      end
   end

   always_ff @(posedge CLK or posedge RES) begin
      if (RES) begin
         strobe_sync_q <= '0;
         rd0_sync_q    <= '1;
         rd1_sync_q    <= '1;
         rd0_prev_q    <= 1'b1;
         rd1_prev_q    <= 1'b1;
         sr0_q         <= 8'h00;
         sr1_q         <= 8'h00;
         cnt0_q        <= 4'd0;
         cnt1_q        <= 4'd0;
         d0_out_q      <= 1'b0;
         d0_oe_q       <= 1'b0;
      end else begin
         strobe_sync_q[0] <= bus.OUT0;
         rd0_sync_q[0]    <= bus.n_IN0;
         rd1_sync_q[0]    <= bus.n_IN1;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            strobe_sync_q[i] <= strobe_sync_q[i-1];
            rd0_sync_q[i]    <= rd0_sync_q[i-1];
            rd1_sync_q[i]    <= rd1_sync_q[i-1];
         end
         rd0_prev_q <= rd0_s;
         rd1_prev_q <= rd1_s;
         sr0_q      <= sr0_d;
         sr1_q      <= sr1_d;
         cnt0_q     <= cnt0_d;
         cnt1_q     <= cnt1_d;
         d0_out_q   <= d0_out_d;
         d0_oe_q    <= d0_oe_d;
      end
   end

   assign bus.D0_OUT = d0_out_q;
   assign bus.D0_OE  = d0_oe_q;
   assign bus.CNT0   = cnt0_q;
   assign bus.CNT1   = cnt1_q;

endmodule

// File: tb/tb_joypad_port.sv
// Directed bench for joypad_port: load, serial readout, overrun, port
// independence, strobe priority, simultaneous reads and async reset.
module tb_joypad_port;

   logic CLK;
   logic RES;
   int   n_cmp;
   int   n_mis;

   joypad_port_if bus ();

   joypad_port #(
      .SYNC_STAGES (2),
      .FILL        (1'b1)
   ) dut (
      .CLK (CLK),
      .RES (RES),
      .bus (bus)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_mis++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic strobe_load(input logic [7:0] b0, input logic [7:0] b1);
      bus.BTN0 = b0;
      bus.BTN1 = b1;
      bus.OUT0 = 1'b1;
      tick(4);
      bus.OUT0 = 1'b0;
      tick(4);
   endtask

   // One read on the given port: low 4 CLK (sample D0 at the end), high 4 CLK.
   task automatic read_port(input int port, input logic exp_bit, input string tag);
      if (port == 0) bus.n_IN0 = 1'b0;
      else           bus.n_IN1 = 1'b0;
      tick(4);
      check({tag, "_d0"}, {7'd0, bus.D0_OUT}, {7'd0, exp_bit});
      check({tag, "_oe"}, {7'd0, bus.D0_OE}, 8'd1);
      if (port == 0) bus.n_IN0 = 1'b1;
      else           bus.n_IN1 = 1'b1;
      tick(4);
   endtask

   initial begin
      logic [7:0] basic_exp;
      n_cmp = 0;
      n_mis = 0;
      bus.OUT0  = 1'b0;
      bus.n_IN0 = 1'b0;
      bus.n_IN1 = 1'b1;
      bus.BTN0  = 8'h00;
      bus.BTN1  = 8'h00;
      RES       = 1'b1;

      #2;
      check("rst_oe",   {7'd0, bus.D0_OE},  8'd0);
      check("rst_d0",   {7'd0, bus.D0_OUT}, 8'd0);
      check("rst_cnt0", {4'd0, bus.CNT0},   8'd0);
      check("rst_cnt1", {4'd0, bus.CNT1},   8'd0);

      tick(2);
      RES = 1'b0;
      bus.n_IN0 = 1'b1;
      tick(4);
      check("idle_oe", {7'd0, bus.D0_OE}, 8'd0);

      // Basic read: bits LSB first.
      basic_exp = 8'b1000_1001;
      strobe_load(basic_exp, 8'h00);
      check("load_cnt0", {4'd0, bus.CNT0}, 8'd0);
      for (int i = 0; i < 8; i++) begin
         read_port(0, basic_exp[i], $sformatf("basic%0d", i));
      end
      check("basic_cnt0", {4'd0, bus.CNT0}, 8'd8);

      for (int i = 0; i < 3; i++) begin
         read_port(0, 1'b1, $sformatf("over%0d", i));
         check($sformatf("over%0d_cnt0", i), {4'd0, bus.CNT0}, 8'd8);
      end

      // Port independence.
      strobe_load(8'b1000_1001, 8'h02);
      read_port(1, 1'b0, "p1_r0");
      read_port(1, 1'b1, "p1_r1");
      read_port(0, 1'b1, "p0_r0");
      check("ind_cnt0", {4'd0, bus.CNT0}, 8'd1);
      check("ind_cnt1", {4'd0, bus.CNT1}, 8'd2);

      // Strobe priority: reads under a held strobe return live BTN0[0], no shift.
      bus.OUT0 = 1'b1;
      bus.BTN0 = 8'h01;
      tick(4);
      read_port(0, 1'b1, "pri0");
      check("pri0_cnt0", {4'd0, bus.CNT0}, 8'd0);
      bus.BTN0 = 8'h00;
      read_port(0, 1'b0, "pri1");
      check("pri1_cnt0", {4'd0, bus.CNT0}, 8'd0);
      bus.BTN0 = 8'h01;
      read_port(0, 1'b1, "pri2");
      check("pri2_cnt0", {4'd0, bus.CNT0}, 8'd0);
      bus.OUT0 = 1'b0;
      tick(4);

      // Simultaneous reads: port 0 wins on D0, both shift on release.
      strobe_load(8'h00, 8'hFF);
      bus.n_IN0 = 1'b0;
      bus.n_IN1 = 1'b0;
      tick(4);
      check("sim_d0", {7'd0, bus.D0_OUT}, 8'd0);
      check("sim_oe", {7'd0, bus.D0_OE},  8'd1);
      bus.n_IN0 = 1'b1;
      bus.n_IN1 = 1'b1;
      tick(4);
      check("sim_cnt0",  {4'd0, bus.CNT0},  8'd1);
      check("sim_cnt1",  {4'd0, bus.CNT1},  8'd1);
      check("sim_oe_off", {7'd0, bus.D0_OE}, 8'd0);

      // Async reset mid-read, then release with the read still low.
      bus.n_IN0 = 1'b0;
      tick(4);
      check("pre_rst_oe", {7'd0, bus.D0_OE}, 8'd1);
      #2 RES = 1'b1;
      #1;
      check("arst_oe",   {7'd0, bus.D0_OE}, 8'd0);
      check("arst_cnt0", {4'd0, bus.CNT0},  8'd0);
      check("arst_cnt1", {4'd0, bus.CNT1},  8'd0);
      tick(1);
      RES = 1'b0;
      tick(4);
      check("rel_oe",   {7'd0, bus.D0_OE},  8'd1);
      check("rel_d0",   {7'd0, bus.D0_OUT}, 8'd0);
      check("rel_cnt0", {4'd0, bus.CNT0},   8'd0);
      bus.n_IN0 = 1'b1;
      tick(4);
      check("rel_shift_cnt0", {4'd0, bus.CNT0}, 8'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
